mult_shift_sequencer: RTL and testbench

MULT_SHIFT_SEQUENCER -- requirements
Module: mult_shift_sequencer

---
 rtl/mips_seq_pkg.sv | 49 ++++
 rtl/mult_shift_sequencer.sv | 138 +++++++++++++
 tb/tb_mult_shift_sequencer.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_seq_pkg.sv
// Shared encodings for the MIPS multicycle sequencers: FSM states, operations,
// shift-register commands and ALUOut mux selects.
package mips_seq_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_SH_LOAD = 4'd1,
        ST_SH_RUN  = 4'd2,
        ST_SH_WB   = 4'd3,
        ST_MUL_RUN = 4'd4,
        ST_MUL_HI  = 4'd5,
        ST_MUL_LO  = 4'd6,
        ST_MUL_ERR = 4'd7
    } seq_state_e;

    typedef enum logic [1:0] {
        OP_MULT = 2'b00,
        OP_SLL  = 2'b01,
        OP_SRL  = 2'b10,
        OP_SRA  = 2'b11
    } seq_op_e;

    typedef enum logic [2:0] {
        FN_NOP  = 3'b000,
        FN_LOAD = 3'b001,
        FN_SLL  = 3'b010,
        FN_SRL  = 3'b011,
        FN_SRA  = 3'b100
    } reg_funct_e;

    typedef enum logic [1:0] {
        SRC_ALU    = 2'b00,
        SRC_SHIFT  = 2'b01,
        SRC_MUL_HI = 2'b10,
        SRC_MUL_LO = 2'b11
    } alu_out_src_e;

    function automatic reg_funct_e shift_funct(input seq_op_e op);
        reg_funct_e f;
        case (op)
            OP_SLL:  f = FN_SLL;
            OP_SRL:  f = FN_SRL;
            OP_SRA:  f = FN_SRA;
            default: f = FN_NOP;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/mult_shift_sequencer.sv
// Moore sequencer for shift (done 3 cycles after start, 2 when shamt=0) and MULT
// (HI then LO write after endMult, err after MULT_TIMEOUT run cycles); start only taken in IDLE.
module mult_shift_sequencer
    import mips_seq_pkg::*;
#(
    parameter int MULT_TIMEOUT = 40
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] op,
    input  logic [4:0] shamt,
    input  logic       endMult,
    output logic       workMult,
    output logic       REG_reset,
    output logic [2:0] REG_funct,
    output logic [4:0] REG_NumberOfShifts,
    output logic [1:0] ALUOutSrc,
    output logic       ALUOut_load,
    output logic       hi_wr,
    output logic       lo_wr,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] StateOut
);

    localparam int CNT_W = $clog2(MULT_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MULT_TIMEOUT - 1);

    seq_state_e       state_q, state_d;
    seq_op_e          op_q, op_d;
    logic [4:0]       shamt_q, shamt_d;
    logic [CNT_W-1:0] wd_q, wd_d;

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_MULT;
            shamt_q <= 5'd0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            shamt_q <= shamt_d;
            wd_q    <= wd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        shamt_d = shamt_q;
        wd_d    = wd_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d    = seq_op_e'(op);
                    shamt_d = shamt;
                    if (seq_op_e'(op) == OP_MULT) begin
                        state_d = ST_MUL_RUN;
                        wd_d    = '0;
                    end else begin
                        state_d = ST_SH_LOAD;
                    end
                end
            end
            ST_SH_LOAD: state_d = (shamt_q == 5'd0) ? ST_SH_WB : ST_SH_RUN;
            ST_SH_RUN:  state_d = ST_SH_WB;
            ST_SH_WB:   state_d = ST_IDLE;
            ST_MUL_RUN: begin
                wd_d = wd_q + 1'b1;
                // A completion in the last allowed cycle still wins over the watchdog.
                if (endMult) begin
                    state_d = ST_MUL_HI;
                end else if (wd_q == WD_LAST) begin
                    state_d = ST_MUL_ERR;
                end
            end
            ST_MUL_HI:  state_d = ST_MUL_LO;
            ST_MUL_LO:  state_d = ST_IDLE;
            ST_MUL_ERR: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        workMult           = 1'b0;
        REG_reset          = 1'b0;
        REG_funct          = FN_NOP;
        REG_NumberOfShifts = 5'd0;
        ALUOutSrc          = SRC_ALU;
        ALUOut_load        = 1'b0;
        hi_wr              = 1'b0;
        lo_wr              = 1'b0;
        done               = 1'b0;
        err                = 1'b0;
        busy               = 1'b0;
        StateOut           = ST_IDLE;
        // Reset masks the registered state so an in-flight op writes nothing.
        if (reset) begin
            REG_reset = 1'b1;
        end else begin
            busy     = (state_q != ST_IDLE);
            StateOut = state_q;
            case (state_q)
                ST_SH_LOAD: REG_funct = FN_LOAD;
                ST_SH_RUN: begin
                    REG_funct          = shift_funct(op_q);
                    REG_NumberOfShifts = shamt_q;
                end
                ST_SH_WB: begin
                    ALUOutSrc   = SRC_SHIFT;
                    ALUOut_load = 1'b1;
                    done        = 1'b1;
                end
                ST_MUL_RUN: workMult = 1'b1;
                ST_MUL_HI: begin
                    ALUOutSrc   = SRC_MUL_HI;
                    ALUOut_load = 1'b1;
                    hi_wr       = 1'b1;
                end
                ST_MUL_LO: begin
                    ALUOutSrc   = SRC_MUL_LO;
                    ALUOut_load = 1'b1;
                    lo_wr       = 1'b1;
                    done        = 1'b1;
                end
                ST_MUL_ERR: begin
                    err       = 1'b1;
                    REG_reset = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_shift_sequencer.sv
// Scoreboard bench: sequencer plus a small shifter/multiplier/ALUOut datapath model.
module tb_mult_shift_sequencer;

    logic       Clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] op;
    logic [4:0] shamt;
    logic       endMult = 1'b0;
    logic       workMult, REG_reset, ALUOut_load, hi_wr, lo_wr, busy, done, err;
    logic [2:0] REG_funct;
    logic [4:0] REG_NumberOfShifts;
    logic [1:0] ALUOutSrc;
    logic [3:0] StateOut;

    mult_shift_sequencer #(.MULT_TIMEOUT(40)) dut (
        .Clk(Clk), .reset(reset), .start(start), .op(op), .shamt(shamt),
        .endMult(endMult), .workMult(workMult), .REG_reset(REG_reset),
        .REG_funct(REG_funct), .REG_NumberOfShifts(REG_NumberOfShifts),
        .ALUOutSrc(ALUOutSrc), .ALUOut_load(ALUOut_load), .hi_wr(hi_wr),
        .lo_wr(lo_wr), .busy(busy), .done(done), .err(err), .StateOut(StateOut)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        bit          is_err;
        int          lat;
        logic [11:0] trace;
        logic [3:0]  st;
        logic [31:0] aluout;
        logic [31:0] hi;
        logic [31:0] lo;
        int          nhi;
        int          nlo;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   t0 = 0;
    logic [11:0] tr = '0;
    int   op_nhi = 0, op_nlo = 0;
    int   tot_hi = 0, tot_lo = 0, tot_done = 0, tot_err = 0;
    int   run_cnt = 0;
    int   end_at = 0;
    bit   spurious = 1'b0;

    logic [31:0] alu_rhs = '0, mul_a = '0, mul_b = '0;
    logic [31:0] sh_q = '0, aluout_q = '0, hi_q = '0, lo_q = '0;
    logic [31:0] cur_ao = '0, cur_hi = '0, cur_lo = '0;
    logic [63:0] prod;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp_v);
    endtask

    assign prod = 64'(mul_a) * 64'(mul_b);

    always @(posedge Clk) begin
        cyc <= cyc + 1;
        if (REG_reset) sh_q <= '0;
        else case (REG_funct)
            3'b001: sh_q <= alu_rhs;
            3'b010: sh_q <= sh_q << REG_NumberOfShifts;
            3'b011: sh_q <= sh_q >> REG_NumberOfShifts;
            3'b100: sh_q <= $signed(sh_q) >>> REG_NumberOfShifts;
            default: ;
        endcase
        if (ALUOut_load) case (ALUOutSrc)
            2'b00: aluout_q <= 32'h0;
            2'b01: aluout_q <= sh_q;
            2'b10: aluout_q <= prod[63:32];
            2'b11: aluout_q <= prod[31:0];
        endcase
        if (hi_wr) hi_q <= prod[63:32];
        if (lo_wr) lo_q <= prod[31:0];
    end

    // Multiplier emulation: endMult in the end_at-th run cycle, else stray pulses if enabled.
    always @(negedge Clk) begin
        if (workMult) begin
            run_cnt = run_cnt + 1;
            endMult = (end_at != 0) && (run_cnt == end_at);
        end else begin
            run_cnt = 0;
            endMult = spurious;
        end
    end

    always @(negedge Clk) begin
        if (!reset) begin
            if (REG_funct != 3'b000) tr = {tr[8:0], REG_funct};
            if (hi_wr) begin op_nhi++; tot_hi++; end
            if (lo_wr) begin op_nlo++; tot_lo++; end
            if (done) tot_done++;
            if (err) tot_err++;
            if (done || err) begin
                chk("done_err_exclusive", 64'(done & err), 64'(0));
                if (sb.size() == 0) begin
                    chk("unexpected_completion", 64'(1), 64'(0));
                end else begin
                    mon_e = sb.pop_front();
                    chk("kind_err", 64'(err), 64'(mon_e.is_err));
                    chk("latency", 64'(cyc - t0), 64'(mon_e.lat));
                    chk("funct_trace", 64'(tr), 64'(mon_e.trace));
                    chk("state_at_end", 64'(StateOut), 64'(mon_e.st));
                    chk("hi_wr_count", 64'(op_nhi), 64'(mon_e.nhi));
                    chk("lo_wr_count", 64'(op_nlo), 64'(mon_e.nlo));
                    @(posedge Clk);
                    #1;
                    chk("aluout", 64'(aluout_q), 64'(mon_e.aluout));
                    chk("hi_reg", 64'(hi_q), 64'(mon_e.hi));
                    chk("lo_reg", 64'(lo_q), 64'(mon_e.lo));
                    chk("idle_after", 64'(StateOut), 64'(0));
                    chk("busy_after", 64'(busy), 64'(0));
                end
            end
        end
    end

    function automatic exp_t mk(input bit is_err, input int lat, input logic [11:0] t,
                                input logic [3:0] st, input logic [31:0] ao,
                                input logic [31:0] hi, input logic [31:0] lo,
                                input int nhi, input int nlo);
        exp_t e;
        e.is_err = is_err; e.lat = lat; e.trace = t; e.st = st;
        e.aluout = ao; e.hi = hi; e.lo = lo; e.nhi = nhi; e.nlo = nlo;
        return e;
    endfunction

    function automatic logic [31:0] shift_ref(input logic [1:0] o, input logic [31:0] a,
                                              input logic [4:0] sa);
        case (o)
            2'b01:   return a << sa;
            2'b10:   return a >> sa;
            default: return 32'($signed(a) >>> sa);
        endcase
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [4:0] sa, input logic [31:0] a,
                          input logic [31:0] b, input int ea, input bit poke, input exp_t e);
        @(negedge Clk);
        alu_rhs = a; mul_a = a; mul_b = b; end_at = ea;
        sb.push_back(e);
        tr = '0; op_nhi = 0; op_nlo = 0; t0 = cyc;
        op = o; shamt = sa; start = 1'b1;
        @(negedge Clk);
        start = 1'b0; op = 2'($urandom); shamt = 5'($urandom);
        if (poke) begin
            @(negedge Clk);
            start = 1'b1; op = 2'b00;
            @(negedge Clk);
            start = 1'b0;
        end
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge Clk);
        if (sb.size() != 0) begin
            chk("completion_timeout", 64'(1), 64'(0));
            sb.delete();
        end
        repeat (3) @(negedge Clk);
    endtask

    task automatic shift_op(input logic [1:0] o, input logic [4:0] sa, input logic [31:0] a,
                            input bit poke);
        logic [2:0]  code;
        logic [11:0] t;
        code = (o == 2'b01) ? 3'b010 : (o == 2'b10) ? 3'b011 : 3'b100;
        t = (sa == 5'd0) ? 12'o0001 : {6'b0, 3'b001, code};
        cur_ao = shift_ref(o, a, sa);
        run_op(o, sa, a, 32'h0, 0, poke,
               mk(1'b0, (sa == 5'd0) ? 2 : 3, t, 4'd3, cur_ao, cur_hi, cur_lo, 0, 0));
    endtask

    initial begin
        int d0, e0, h0, l0, bc;
        logic [63:0] p;
        reset = 1'b1; start = 1'b0; op = 2'b00; shamt = 5'd0;
        repeat (3) @(negedge Clk);
        chk("rst_REG_reset", 64'(REG_reset), 64'(1));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_state", 64'(StateOut), 64'(0));
        chk("rst_strobes", 64'({workMult, ALUOut_load, hi_wr, lo_wr, done, err}), 64'(0));
        chk("rst_funct", 64'({REG_funct, REG_NumberOfShifts, ALUOutSrc}), 64'(0));
        reset = 1'b0;
        #1;
        chk("post_rst_REG_reset", 64'(REG_reset), 64'(0));
        chk("post_rst_state", 64'(StateOut), 64'(0));

        // Directed shifts: SRL by 4, SLL by 0 (SH_RUN skipped), SRA by 31.
        cur_ao = 32'h0800_0000;
        run_op(2'b10, 5'd4, 32'h8000_0000, 32'h0, 0, 1'b0,
               mk(1'b0, 3, 12'o0013, 4'd3, 32'h0800_0000, cur_hi, cur_lo, 0, 0));
        cur_ao = 32'h1234_5678;
        run_op(2'b01, 5'd0, 32'h1234_5678, 32'h0, 0, 1'b0,
               mk(1'b0, 2, 12'o0001, 4'd3, 32'h1234_5678, cur_hi, cur_lo, 0, 0));
        cur_ao = 32'hFFFF_FFFF;
        run_op(2'b11, 5'd31, 32'h8000_0001, 32'h0, 0, 1'b0,
               mk(1'b0, 3, 12'o0014, 4'd3, 32'hFFFF_FFFF, cur_hi, cur_lo, 0, 0));

        // Random shifts with stray endMult pulses that must be ignored.
        spurious = 1'b1;
        for (int k = 0; k < 5; k++)
            shift_op(2'($urandom_range(3, 1)), 5'($urandom_range(31, 0)), $urandom, 1'b0);
        spurious = 1'b0;

        // MULT 0xFFFFFFFF x 2, endMult in run cycle 33.
        cur_hi = 32'h1; cur_lo = 32'hFFFF_FFFE; cur_ao = cur_lo;
        run_op(2'b00, 5'd0, 32'hFFFF_FFFF, 32'h2, 33, 1'b0,
               mk(1'b0, 35, 12'o0, 4'd6, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFE, 1, 1));

        // endMult in the 40th run cycle beats the watchdog.
        cur_hi = 32'h1; cur_lo = 32'h0; cur_ao = 32'h0;
        run_op(2'b00, 5'd0, 32'h0001_0000, 32'h0001_0000, 40, 1'b0,
               mk(1'b0, 42, 12'o0, 4'd6, 32'h0, 32'h1, 32'h0, 1, 1));

        // Random MULT with the result checked against a 64-bit reference.
        mul_a = $urandom; mul_b = $urandom;
        p = 64'(mul_a) * 64'(mul_b);
        cur_hi = p[63:32]; cur_lo = p[31:0]; cur_ao = p[31:0];
        run_op(2'b00, 5'd0, mul_a, mul_b, 7, 1'b0,
               mk(1'b0, 9, 12'o0, 4'd6, cur_ao, cur_hi, cur_lo, 1, 1));

        // Watchdog: endMult never comes, err after 40 run cycles; stray endMult outside run.
        spurious = 1'b1;
        run_op(2'b00, 5'd0, 32'h5, 32'h7, 0, 1'b0,
               mk(1'b1, 41, 12'o0, 4'd7, cur_ao, cur_hi, cur_lo, 0, 0));
        spurious = 1'b0;

        // Reset in the middle of MUL_RUN aborts with no writes and no completion.
        d0 = tot_done; e0 = tot_err; h0 = tot_hi; l0 = tot_lo;
        @(negedge Clk);
        end_at = 0; op = 2'b00; shamt = 5'd0; start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        repeat (4) @(negedge Clk);
        chk("mid_busy_before_reset", 64'(busy), 64'(1));
        reset = 1'b1;
        #1;
        chk("mid_rst_REG_reset", 64'(REG_reset), 64'(1));
        chk("mid_rst_state", 64'(StateOut), 64'(0));
        chk("mid_rst_workMult", 64'(workMult), 64'(0));
        @(negedge Clk);
        reset = 1'b0;
        repeat (50) @(negedge Clk);
        chk("abort_done_count", 64'(tot_done), 64'(d0));
        chk("abort_err_count", 64'(tot_err), 64'(e0));
        chk("abort_hilo_writes", 64'(tot_hi + tot_lo), 64'(h0 + l0));
        chk("abort_idle", 64'(StateOut), 64'(0));

        // start pulsed while a shift is in SH_RUN must not spawn a MULT.
        shift_op(2'b10, 5'd2, 32'h0000_00F0, 1'b1);
        bc = 0;
        repeat (10) begin
            @(negedge Clk);
            if (busy) bc++;
        end
        chk("busy_start_ignored", 64'(bc), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
